// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Control-in / display-out bundle between the stopwatch
//               synchronizers, the sequencer and the 7-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic        run_level;
    logic        init_pulse;
    logic        lap_pulse;
    logic        clear_pulse;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport master (
        output run_level, init_pulse, lap_pulse, clear_pulse,
        input  disp_bcd, running, lap_active, overflow
    );

    modport slave (
        input  run_level, init_pulse, lap_pulse, clear_pulse,
        output disp_bcd, running, lap_active, overflow
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencer - prescaler, MM:SS.cc BCD counters and
//               lap freeze. Define SW_AUTOSTOP_EN to stop at 59:59.99
//               instead of rolling over.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  wire logic       clk,
    input  wire logic       rst,
    stopwatch_ctrl_if.slave sw
);

    localparam int              c_DIV = CLK_HZ / TICK_HZ;
    localparam int              c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_PW-1:0] c_TOP = c_PW'(c_DIV - 1);
    localparam logic [23:0]     c_MAX = 24'h595999;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_LAP     = 2'd2;
    localparam logic [1:0] c_STOPPED = 2'd3;

    generate
        if (c_DIV < 2) begin : g_div_check
            $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_PW-1:0] r_presc;
    logic [23:0]     r_cnt;
    logic [23:0]     r_lap;
    logic            r_overflow;

    logic            w_active;
    logic            w_start;
    logic            w_clear;
    logic            w_count_en;
    logic            w_tick;
    logic            w_lap_capture;
    logic [23:0]     w_cnt_inc;
    logic            w_wrap;

    assign w_active      = (r_state == c_RUN) || (r_state == c_LAP);
    assign w_start       = sw.init_pulse && sw.run_level &&
                           ((r_state == c_IDLE) || (r_state == c_STOPPED));
    assign w_clear       = sw.clear_pulse && (r_state == c_STOPPED) && !w_start;
    assign w_count_en    = w_active && sw.run_level;
    assign w_tick        = w_count_en && (r_presc == c_TOP);
    assign w_lap_capture = (r_state == c_RUN) && (w_state_next == c_LAP);

    // Ripple the carry through all six digits combinationally; w_wrap ends
    // high only when every digit was at its maximum (59:59.99).
    always_comb begin
        w_cnt_inc = r_cnt;
        w_wrap    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_wrap) begin
                if (r_cnt[i*4 +: 4] >= c_MAX[i*4 +: 4]) begin
                    w_cnt_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
                    w_wrap              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = c_RUN;
        end else if (w_active && !sw.run_level) begin
            w_state_next = c_STOPPED;
`ifdef SW_AUTOSTOP_EN
        end else if (w_tick && w_wrap) begin
            w_state_next = c_STOPPED;
`endif
        end else if (sw.lap_pulse && (r_state == c_RUN)) begin
            w_state_next = c_LAP;
        end else if (sw.lap_pulse && (r_state == c_LAP)) begin
            w_state_next = c_RUN;
        end else if (w_clear) begin
            w_state_next = c_IDLE;
        end
    end

    always_comb begin
        sw.running    = w_active;
        sw.lap_active = (r_state == c_LAP);
        sw.disp_bcd   = (r_state == c_LAP) ? r_lap : r_cnt;
        sw.overflow   = r_overflow;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start || w_clear) begin
            r_presc    <= '0;
            r_cnt      <= '0;
            r_lap      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_count_en) begin
                r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            end
            if (w_tick) begin
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
`ifdef SW_AUTOSTOP_EN
                if (!w_wrap) begin
                    r_cnt <= w_cnt_inc;
                end
`else
                r_cnt <= w_cnt_inc;
`endif
            end
            // Lap freezes the value present this cycle, before any tick lands.
            if (w_lap_capture) begin
                r_lap <= r_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl, DIV = 10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance n active edges and land 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        sw_if.run_level  = 1'b1;
        sw_if.init_pulse = 1'b1;
        step(1);
        sw_if.init_pulse = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        sw_if.run_level   = 1'b0;
        sw_if.init_pulse  = 1'b0;
        sw_if.lap_pulse   = 1'b0;
        sw_if.clear_pulse = 1'b0;

        // Reset
        step(2);
        rst = 1'b0;
        step(1);
        check_eq("rst_disp", {8'h0, sw_if.disp_bcd}, 32'h000000);
        check_eq("rst_running", {31'b0, sw_if.running}, 32'd0);
        check_eq("rst_lap", {31'b0, sw_if.lap_active}, 32'd0);
        check_eq("rst_ovf", {31'b0, sw_if.overflow}, 32'd0);

        // Start and count: first tick lands 10 edges after the start edge
        start_run();
        check_eq("start_running", {31'b0, sw_if.running}, 32'd1);
        step(9);
        check_eq("pre_first_tick", {8'h0, sw_if.disp_bcd}, 32'h000000);
        step(1);
        check_eq("first_tick", {8'h0, sw_if.disp_bcd}, 32'h000001);
        step(990);
        check_eq("one_second", {8'h0, sw_if.disp_bcd}, 32'h000100);

        // Carry chain 00:59.99 -> 01:00.00
        step(58990);
        check_eq("at_5999", {8'h0, sw_if.disp_bcd}, 32'h005999);
        step(9);
        check_eq("hold_5999", {8'h0, sw_if.disp_bcd}, 32'h005999);
        step(1);
        check_eq("carry_chain", {8'h0, sw_if.disp_bcd}, 32'h010000);

        // Stop, then restart clears everything
        sw_if.run_level = 1'b0;
        step(1);
        check_eq("stop_running", {31'b0, sw_if.running}, 32'd0);
        check_eq("stop_hold", {8'h0, sw_if.disp_bcd}, 32'h010000);
        start_run();
        check_eq("restart_clear", {8'h0, sw_if.disp_bcd}, 32'h000000);

        // Lap at 00:01.23, release at live 00:02.50
        step(1230);
        sw_if.lap_pulse = 1'b1;
        step(1);
        sw_if.lap_pulse = 1'b0;
        check_eq("lap_active", {31'b0, sw_if.lap_active}, 32'd1);
        check_eq("lap_freeze", {8'h0, sw_if.disp_bcd}, 32'h000123);
        step(1269);
        check_eq("lap_still_frozen", {8'h0, sw_if.disp_bcd}, 32'h000123);
        sw_if.lap_pulse = 1'b1;
        step(1);
        sw_if.lap_pulse = 1'b0;
        check_eq("lap_release", {8'h0, sw_if.disp_bcd}, 32'h000250);
        check_eq("lap_release_flag", {31'b0, sw_if.lap_active}, 32'd0);

        // Lap on a tick edge captures the pre-increment value
        step(8);
        sw_if.lap_pulse = 1'b1;
        step(1);
        sw_if.lap_pulse = 1'b0;
        check_eq("lap_on_tick", {8'h0, sw_if.disp_bcd}, 32'h000250);
        sw_if.lap_pulse = 1'b1;
        step(1);
        sw_if.lap_pulse = 1'b0;
        check_eq("lap_on_tick_live", {8'h0, sw_if.disp_bcd}, 32'h000251);

        // Run_level falls on the tick that would leave 00:00.05
        sw_if.run_level = 1'b0;
        step(1);
        start_run();
        step(59);
        sw_if.run_level = 1'b0;
        step(1);
        check_eq("coinc_running", {31'b0, sw_if.running}, 32'd0);
        check_eq("coinc_disp", {8'h0, sw_if.disp_bcd}, 32'h000005);
        step(20);
        check_eq("stopped_hold", {8'h0, sw_if.disp_bcd}, 32'h000005);

        // Clear from STOPPED
        sw_if.clear_pulse = 1'b1;
        step(1);
        sw_if.clear_pulse = 1'b0;
        check_eq("clear_disp", {8'h0, sw_if.disp_bcd}, 32'h000000);

        // init_pulse without run_level is ignored
        sw_if.init_pulse = 1'b1;
        step(1);
        sw_if.init_pulse = 1'b0;
        check_eq("init_no_level", {31'b0, sw_if.running}, 32'd0);

        // clear_pulse during RUN is ignored
        start_run();
        step(25);
        sw_if.clear_pulse = 1'b1;
        step(1);
        sw_if.clear_pulse = 1'b0;
        check_eq("clear_in_run", {31'b0, sw_if.running}, 32'd1);
        step(4);
        check_eq("clear_in_run_cnt", {8'h0, sw_if.disp_bcd}, 32'h000003);

        // Rollover: preload the counter just short of 59:59.99
        dut.r_cnt = 24'h595998;
        step(10);
        check_eq("at_max", {8'h0, sw_if.disp_bcd}, 32'h595999);
        check_eq("at_max_ovf", {31'b0, sw_if.overflow}, 32'd0);
        step(10);
        check_eq("rollover_ovf", {31'b0, sw_if.overflow}, 32'd1);
`ifdef SW_AUTOSTOP_EN
        check_eq("rollover_disp", {8'h0, sw_if.disp_bcd}, 32'h595999);
        check_eq("rollover_running", {31'b0, sw_if.running}, 32'd0);
        step(10);
        check_eq("after_rollover", {8'h0, sw_if.disp_bcd}, 32'h595999);
`else
        check_eq("rollover_disp", {8'h0, sw_if.disp_bcd}, 32'h000000);
        check_eq("rollover_running", {31'b0, sw_if.running}, 32'd1);
        step(10);
        check_eq("after_rollover", {8'h0, sw_if.disp_bcd}, 32'h000001);
`endif
        check_eq("ovf_sticky", {31'b0, sw_if.overflow}, 32'd1);

        // Reset mid-run takes priority
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("midrun_rst_disp", {8'h0, sw_if.disp_bcd}, 32'h000000);
        check_eq("midrun_rst_running", {31'b0, sw_if.running}, 32'd0);
        check_eq("midrun_rst_ovf", {31'b0, sw_if.overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
